// File: rtl/packet_arb_pkg.sv
// Shared types and helpers for the packet weighted round-robin arbiter.
// Exports state_t, the weight floor and a one-hot to index encoder.
package packet_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A programmed weight of 0 still grants one packet per turn.
    localparam int unsigned MIN_WEIGHT = 1;

    // Widest one-hot vector onehot2idx accepts.
    localparam int unsigned OH_MAX = 64;

    // OR of the indices of set bits; exact for one-hot or zero input.
    function automatic int unsigned onehot2idx(
        input logic [OH_MAX-1:0] oh
    );
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < OH_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/packet_wrr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req at or after ptr.
// Ports: req, ptr in; onehot, idx (winner), any (req non-zero) out.
module rr_pick
    import packet_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IDW = $clog2(N);

    logic [N-1:0]      win;
    logic [N-1:0]      first;
    logic [2*N-1:0]    rot;
    logic [OH_MAX-1:0] oh_w;

    always_comb begin
        // Rotate req so ptr lands at bit 0, keep lowest set bit,
        // then rotate the winner back into place.
        win    = N'({req, req} >> ptr);
        first  = win & (~win + N'(1));
        rot    = {{N{1'b0}}, first} << ptr;
        onehot = rot[N-1:0] | rot[2*N-1:N];
        oh_w   = '0;
        oh_w[N-1:0] = onehot;
        idx    = IDW'(onehot2idx(oh_w));
        any    = |req;
    end

endmodule

// File: rtl/packet_wrr_arbiter.sv
// Packet-level weighted round-robin arbiter with back-to-back handover
// and stuck-packet watchdog. Ports: clock, reset_n, req/fin (per channel),
// ready, weight (N*WW) in; grant, grant_valid, grant_id, timeout,
// timeout_id out. Grant is held for a whole packet until the owner's fin.
module packet_wrr_arbiter
    import packet_arb_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned WW      = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         fin,
    input  logic                 ready,
    input  logic [N*WW-1:0]      weight,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 timeout,
    output logic [$clog2(N)-1:0] timeout_id
);

    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned CW =
        (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned LAST =
        (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit WD_EN = (TIMEOUT > 0);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [WW-1:0]  credit_q, credit_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic           to_q, to_d;
    logic [IDW-1:0] toid_q, toid_d;

    logic [IDW-1:0] owner_nxt;
    logic [IDW-1:0] pick_ptr;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   pick_req;
    logic [N-1:0]   pick_oh;
    logic           pick_any;
    logic [WW-1:0]  pick_w;
    logic           owner_fin;
    logic           keep_turn;
    logic           expired;

    function automatic logic [WW-1:0] credit_of(
        input logic [WW-1:0] w
    );
        return (w > WW'(MIN_WEIGHT)) ?
            w - WW'(MIN_WEIGHT) : '0;
    endfunction

    // While busy the picker already looks past the owner, so a
    // finishing packet can hand over without an idle cycle.
    assign owner_nxt = (gid_q == IDW'(N - 1)) ?
        '0 : gid_q + IDW'(1);
    assign pick_ptr  = (state_q == BUSY) ? owner_nxt : ptr_q;
    assign pick_req  = req & {N{ready}};
    assign pick_w    = weight[int'(pick_idx) * WW +: WW];
    assign owner_fin = fin[gid_q];
    assign keep_turn = owner_fin && (credit_q != '0) &&
        req[gid_q] && ready;
    assign expired   = WD_EN && (cnt_q == CW'(LAST));

    rr_pick #(
        .N(N)
    ) u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        gid_d    = gid_q;
        to_d     = 1'b0;
        toid_d   = toid_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = BUSY;
                    grant_d  = pick_oh;
                    gid_d    = pick_idx;
                    credit_d = credit_of(pick_w);
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                if (keep_turn) begin
                    credit_d = credit_q - WW'(1);
                    cnt_d    = '0;
                end else if (owner_fin) begin
                    ptr_d = owner_nxt;
                    if (pick_any) begin
                        grant_d  = pick_oh;
                        gid_d    = pick_idx;
                        credit_d = credit_of(pick_w);
                        cnt_d    = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        gid_d   = '0;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                    grant_d = '0;
                    gid_d   = '0;
                    ptr_d   = owner_nxt;
                    to_d    = 1'b1;
                    toid_d  = gid_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            gid_q    <= '0;
            to_q     <= 1'b0;
            toid_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            to_q     <= to_d;
            toid_q   <= toid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = gid_q;
    assign timeout     = to_q;
    assign timeout_id  = toid_q;

endmodule
